// File: rtl/bus_loader.sv
// ---------------------------------------------------------------------------
// bus_loader
// Bus initiator for the TRS-80 memory bus. While a session runs, the CPU is
// held off and this block drives Z80-style memory cycles into the
// address-decode / chip-select logic.
//   mode 0 (write/load): bytes from the s_* download channel are written to
//                        memory starting at base_addr.
//   mode 1 (read/verify): memory is read back and streamed out on m_*.
// In both modes checksum accumulates the sum mod 256 of every byte moved.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   start, mode           session start pulse, direction (sampled at start)
//   base_addr, length     first address and byte count (sampled at start)
//   s_data/s_valid/s_ready  write-mode source stream
//   m_data/m_valid/m_ready  read-mode sink stream
//   bus_mreq_n/wr_n/rd_n  active-low memory request and strobes
//   bus_addr, bus_dout    bus address and write data
//   bus_din               read data from the chip-select mux
//   cpu_hold, busy        high for the whole session
//   done                  one-clock pulse at the end of a session
//   checksum              running byte sum of the current/last session
// ---------------------------------------------------------------------------
module bus_loader #(
  parameter int ACCESS_CYCLES = 3,
  parameter int ADDR_W        = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       length,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              bus_mreq_n,
  output logic              bus_wr_n,
  output logic              bus_rd_n,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_dout,
  input  logic [7:0]        bus_din,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [7:0]        checksum
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_DELIVER = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Strobe counter terminal value: strobes are low for counts 0..ACC_LAST.
  localparam logic [3:0]        ACC_LAST = 4'(ACCESS_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t      state_r;
  logic        mode_r;
  logic [15:0] remaining_r;
  logic [3:0]  acc_cnt_r;

  // Source is only accepted while waiting for a write byte.
  assign s_ready = (state_r == ST_FETCH) && (mode_r == 1'b0);

  // Session sequencer: state, bus cycle outputs, stream outputs and checksum.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      mode_r      <= 1'b0;
      remaining_r <= 16'd0;
      acc_cnt_r   <= 4'd0;
      bus_mreq_n  <= 1'b1;
      bus_wr_n    <= 1'b1;
      bus_rd_n    <= 1'b1;
      bus_addr    <= '0;
      bus_dout    <= 8'd0;
      m_data      <= 8'd0;
      m_valid     <= 1'b0;
      cpu_hold    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      checksum    <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // busy still high here means the done pulse is showing; the
          // session ends on this clock and start stays ignored until then.
          if (busy) begin
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
          end else if (start) begin
            mode_r      <= mode;
            bus_addr    <= base_addr;
            remaining_r <= length;
            checksum    <= 8'd0;
            busy        <= 1'b1;
            cpu_hold    <= 1'b1;
            state_r     <= (length == 16'd0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          // Address has been stable since IDLE/RELEASE, so strobes may fall
          // on the transition into ACCESS.
          if (mode_r) begin
            bus_mreq_n <= 1'b0;
            bus_rd_n   <= 1'b0;
            acc_cnt_r  <= 4'd0;
            state_r    <= ST_ACCESS;
          end else if (s_valid) begin
            bus_dout   <= s_data;
            checksum   <= checksum + s_data;
            bus_mreq_n <= 1'b0;
            bus_wr_n   <= 1'b0;
            acc_cnt_r  <= 4'd0;
            state_r    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (acc_cnt_r == ACC_LAST) begin
            bus_mreq_n <= 1'b1;
            bus_wr_n   <= 1'b1;
            bus_rd_n   <= 1'b1;
            if (mode_r) begin
              m_data   <= bus_din;
              checksum <= checksum + bus_din;
              m_valid  <= 1'b1;
              state_r  <= ST_DELIVER;
            end else begin
              state_r  <= ST_RELEASE;
            end
          end else begin
            acc_cnt_r <= acc_cnt_r + 4'd1;
          end
        end
        ST_DELIVER: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state_r <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          bus_addr    <= bus_addr + ADDR_ONE;
          remaining_r <= remaining_r - 16'd1;
          state_r     <= (remaining_r == 16'd1) ? ST_DONE : ST_FETCH;
        end
        ST_DONE: begin
          done    <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          bus_mreq_n <= 1'b1;
          bus_wr_n   <= 1'b1;
          bus_rd_n   <= 1'b1;
          m_valid    <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bus_loader.md
Name: bus_loader

Overview:
- Bus initiator for the TRS-80 memory bus.
- Drives Z80-style memory cycles (mreq_n, wr_n, rd_n, address, data) into the address-decode/chip-select logic while the CPU is held off.
- Write mode: copies a byte stream from the host download channel into memory starting at a base address.
- Read mode: reads a memory range back out as a byte stream for verify/dump. Keeps a running 8-bit checksum in both modes.

Parameters:
- ACCESS_CYCLES, 3, clocks a strobe stays low per access (1..15).
- ADDR_W, 16, bus address width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-clock pulse; begins a session (ignored while busy)
- mode  in  1  sampled at start: 0 = write/load, 1 = read/verify
- base_addr  in  ADDR_W  first address, sampled at start
- length  in  16  byte count, sampled at start; 0 = empty session
- s_data  in  8  write-mode source byte
- s_valid  in  1  s_data valid
- s_ready  out  1  byte accepted this cycle (s_valid && s_ready)
- m_data  out  8  read-mode byte
- m_valid  out  1  m_data valid; held until accepted
- m_ready  in  1  sink accepts m_data
- bus_mreq_n  out  1  memory request, active low
- bus_wr_n  out  1  write strobe, active low
- bus_rd_n  out  1  read strobe, active low
- bus_addr  out  ADDR_W  bus address
- bus_dout  out  8  write data
- bus_din  in  8  read data from chip-select mux
- cpu_hold  out  1  high while busy; CPU tri-stated/halted, bus mux selects loader
- busy  out  1  session in progress
- done  out  1  one-clock pulse at session end
- checksum  out  8  sum mod 256 of all bytes transferred this session

Behaviour:
- Reset values: bus_mreq_n/wr_n/rd_n = 1; bus_addr = 0; bus_dout = 0; s_ready = 0; m_valid = 0; m_data = 0; cpu_hold = 0; busy = 0; done = 0; checksum = 0; state IDLE.
- All outputs are registered except s_ready, which is combinational: s_ready = (state == FETCH && mode == 0).
- States:
  - IDLE: on start, latch mode, base_addr and length; clear checksum; set busy and cpu_hold. Go to DONE if length == 0, else FETCH.
  - FETCH, write mode: wait for s_valid. On handshake, latch bus_dout = s_data, add it to checksum, go to ACCESS.
  - FETCH, read mode: go straight to ACCESS; no wait.
  - ACCESS: bus_mreq_n = 0, plus bus_wr_n = 0 (write) or bus_rd_n = 0 (read), for exactly ACCESS_CYCLES clocks. bus_addr and bus_dout are stable throughout. In read mode, bus_din is sampled on the last ACCESS clock into m_data and added to checksum; next state DELIVER. In write mode, next state RELEASE.
  - DELIVER: m_valid = 1 until m_ready is seen; strobes stay high. Then go to RELEASE.
  - RELEASE: strobes high for one clock; bus_addr += 1, wrapping 0xFFFF -> 0x0000; remaining -= 1. If remaining reaches 0 go to DONE, else FETCH.
  - DONE: done = 1 for one clock; busy and cpu_hold drop on the next clock; return to IDLE.
- Strobe sequencing: address is set up at least one clock before any strobe falls (bus_addr updates in IDLE/RELEASE, strobes fall on ACCESS entry). bus_wr_n and bus_rd_n are never low together. Strobes are never low outside ACCESS.
- Minimum cost per byte: write = 1 (FETCH) + ACCESS_CYCLES + 1 (RELEASE) clocks; read adds at least 1 DELIVER clock.
- start while busy: ignored; latched parameters unchanged.
- s_valid outside FETCH, or in read mode: ignored; s_ready stays 0.
- reset mid-session: on the next edge all strobes go high, cpu_hold/busy = 0, no done pulse, state IDLE. Partially written memory is left as is.
- checksum holds its final value after DONE until the next start.

Test Plan:
- Write 4 bytes: start, mode=0, base=0x4000, length=4; stream 0x11,0x22,0x33,0x44 -> four write cycles at 0x4000..0x4003, each with mreq_n/wr_n low exactly 3 clocks; rd_n stays 1; done pulses once; checksum = 0xAA; cpu_hold falls the clock after done.
- Read 3 bytes: mode=1, base=0x3C00, length=3; bus_din model returns addr[7:0] -> m_data = 0x00,0x01,0x02; m_ready stalled 5 clocks on byte 1 -> m_valid held, strobes high and address stable during the stall; checksum = 0x03.
- Wrap: mode=0, base=0xFFFF, length=2 -> writes at 0xFFFF then 0x0000.
- Empty and ignored starts: length=0 -> done pulses 2 clocks after start with no strobe activity and checksum = 0; a second start pulse during a length-4 session -> ignored, and exactly 4 cycles occur.
- Source stall: s_valid low for 10 clocks between bytes -> loader waits in FETCH with strobes high and s_ready = 1.
- Reset during write ACCESS of byte 2 -> next clock all strobes = 1, busy = 0, no done pulse; a fresh session afterwards runs normally.
